// File: rtl/voice_change_frame_ctrl.sv
// -----------------------------------------------------------------------------
// voice_change_frame_ctrl
//
// Read-side sequencer for the voice-change sample FIFO, running entirely in
// the FIFO read-clock domain. It waits until a whole analysis frame is
// buffered, bursts exactly FRAME_LEN reads, and forwards the samples to the
// processing core over a valid/ready stream tagged with start/end of frame.
// A flush sequence drains and discards the FIFO contents, and a sticky flag
// records any underrun seen while a frame was being read.
//
// Ports
//   clk                  FIFO read clock, all logic on the rising edge
//   rst                  synchronous active-high reset
//   enable               allows new frames to start
//   flush_req            one-cycle request to drain and discard the FIFO
//   fifo_rd_en           FIFO read enable
//   fifo_rd_data         FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_empty        FIFO empty flag
//   fifo_rd_water_level  FIFO read-side fill level (DEPTH_WIDTH+1 bits)
//   m_data/m_valid/m_ready  sample stream to the processing core
//   m_sof/m_eof          first / last sample of a frame (qualified by m_valid)
//   busy                 high whenever the sequencer is not idle
//   frame_cnt            completed frames, wraps
//   underrun_err         sticky, FIFO ran empty in the middle of a frame
// -----------------------------------------------------------------------------
module voice_change_frame_ctrl #(
  parameter int DEPTH_WIDTH = 11,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_LEN   = 256,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush_req,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic [DEPTH_WIDTH:0]  fifo_rd_water_level,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  underrun_err
);

  localparam int RW = DEPTH_WIDTH + 1;
  localparam logic [RW-1:0] FRAME_LEN_W = RW'(FRAME_LEN);
  localparam logic [RW-1:0] LAST_IDX    = RW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t          state;
  logic [RW-1:0]   reads_issued;   // reads issued in the current frame
  logic            rd_keep_q;      // a frame read is in flight (data arrives now)
  logic            rd_any_q;       // any read (frame or flush) is in flight
  logic            inf_sof;        // tags belonging to the in-flight frame read
  logic            inf_eof;
  logic            empty_seen;     // flush: empty already seen on the previous cycle

  // Two-entry sample buffer, entry 0 is the oldest.
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic                  buf_sof  [2];
  logic                  buf_eof  [2];

  logic [1:0]            nxt_occ;
  logic [DATA_WIDTH-1:0] nxt_data [2];
  logic                  nxt_sof  [2];
  logic                  nxt_eof  [2];

  logic                  pop;
  logic                  burst_rd;
  logic                  flush_rd;
  logic [2:0]            level;
  logic                  room;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_sof;
  logic                  head_eof;

  // ---------------------------------------------------------------------------
  // Output head. When the buffer is empty the in-flight sample is forwarded
  // straight from the FIFO, which gives one cycle from read to m_valid. If it
  // is not accepted it is captured into entry 0 on the same edge, so the
  // presented value stays stable while the core stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (occ != 2'd0) begin
      head_data = buf_data[0];
      head_sof  = buf_sof[0];
      head_eof  = buf_eof[0];
    end else begin
      head_data = fifo_rd_data;
      head_sof  = inf_sof;
      head_eof  = inf_eof;
    end
  end

  assign m_valid = (occ != 2'd0) || rd_keep_q;
  assign m_data  = m_valid ? head_data : '0;
  assign m_sof   = m_valid && head_sof;
  assign m_eof   = m_valid && head_eof;
  assign pop     = m_valid && m_ready;
  assign busy    = (state != S_IDLE);

  // Entries already held or on their way, minus the one leaving this cycle.
  // A new read is allowed only if its sample is guaranteed a slot.
  assign level    = {1'b0, occ} + {2'b00, rd_keep_q};
  assign room     = (level - {2'b00, pop}) < 3'd2;

  assign burst_rd = (state == S_BURST) && !fifo_rd_empty &&
                    (reads_issued < FRAME_LEN_W) && room;
  assign flush_rd = (state == S_FLUSH) && !fifo_rd_empty;

  assign fifo_rd_en = !rst && (burst_rd || flush_rd);

  // ---------------------------------------------------------------------------
  // Next buffer contents: shift out on pop, then append the arriving sample.
  // If the buffer was empty and the bypassed sample is accepted, nothing is
  // stored.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of always_comb; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    nxt_occ  = occ;
    nxt_data = buf_data;
    nxt_sof  = buf_sof;
    nxt_eof  = buf_eof;

    if (pop && (occ != 2'd0)) begin
      nxt_data[0] = buf_data[1];
      nxt_sof[0]  = buf_sof[1];
      nxt_eof[0]  = buf_eof[1];
      nxt_occ     = occ - 2'd1;
    end

    if (rd_keep_q && !(pop && (occ == 2'd0))) begin
      nxt_data[nxt_occ[0]] = fifo_rd_data;
      nxt_sof[nxt_occ[0]]  = inf_sof;
      nxt_eof[nxt_occ[0]]  = inf_eof;
      nxt_occ              = nxt_occ + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer, counters, flags and buffer storage.
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      reads_issued <= '0;
      rd_keep_q    <= 1'b0;
      rd_any_q     <= 1'b0;
      inf_sof      <= 1'b0;
      inf_eof      <= 1'b0;
      empty_seen   <= 1'b0;
      frame_cnt    <= '0;
      underrun_err <= 1'b0;
      occ          <= 2'd0;
      // NOTE: the buffer is only two entries of flops, so it is cleared with
      // everything else; a RAM-sized store would be left unreset.
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_sof[i]  <= 1'b0;
        buf_eof[i]  <= 1'b0;
      end
    end else begin
      occ       <= nxt_occ;
      buf_data  <= nxt_data;
      buf_sof   <= nxt_sof;
      buf_eof   <= nxt_eof;
      rd_keep_q <= burst_rd;
      rd_any_q  <= fifo_rd_en;

      // Tags are taken from the read index at issue time and travel with
      // the sample.
      if (burst_rd) begin
        reads_issued <= reads_issued + RW'(1);
        inf_sof      <= (reads_issued == '0);
        inf_eof      <= (reads_issued == LAST_IDX);
      end

      if (pop && head_eof)
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);

      if ((state == S_BURST) && (reads_issued < FRAME_LEN_W) && fifo_rd_empty)
        underrun_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (flush_req) begin
            state      <= S_FLUSH;
            empty_seen <= 1'b0;
          end else if (enable) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (flush_req) begin
            state      <= S_FLUSH;
            empty_seen <= 1'b0;
          end else if (!enable) begin
            state <= S_IDLE;
          end else if (fifo_rd_water_level >= FRAME_LEN_W) begin
            state        <= S_BURST;
            reads_issued <= '0;
          end
        end

        S_BURST: begin
          if (burst_rd && (reads_issued == LAST_IDX))
            state <= S_DRAIN;
        end

        // Leave once the eof sample has been handed over and nothing is
        // left in flight or buffered.
        S_DRAIN: begin
          if (!rd_keep_q && (occ == 2'd0))
            state <= enable ? S_WAIT : S_IDLE;
        end

        // Two consecutive empty cycles with no read outstanding means the
        // last discarded word has come back and the FIFO really is drained.
        S_FLUSH: begin
          if (fifo_rd_empty && !rd_any_q) begin
            if (empty_seen)
              state <= S_IDLE;
            else
              empty_seen <= 1'b1;
          end else begin
            empty_seen <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/voice_change_frame_ctrl.md
Name: voice_change_frame_ctrl

Overview:
- Read-side sequencer for the 2048 x 16 voice-change sample FIFO. It runs in the FIFO read-clock domain.
- Watches the FIFO read water level. Once a full analysis frame is buffered, it bursts exactly FRAME_LEN reads.
- Forwards the read samples to the voice-change processing core over a valid/ready stream, tagging start and end of frame.
- Also provides a flush (read-and-discard) sequence and a sticky underrun flag.

Parameters:
DEPTH_WIDTH, 11, FIFO depth width; the water-level input is DEPTH_WIDTH+1 bits.
DATA_WIDTH, 16, sample width.
FRAME_LEN, 256, samples per frame; legal range 2 to 2^DEPTH_WIDTH.
CNT_WIDTH, 16, width of the frame counter.

Ports:
clk  in  1  the FIFO read clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  allows new frames to start.
flush_req  in  1  single-cycle pulse requesting the FIFO be drained and its data discarded.
fifo_rd_en  out  1  FIFO read enable.
fifo_rd_data  in  DATA_WIDTH  FIFO read data; valid exactly 1 cycle after fifo_rd_en.
fifo_rd_empty  in  1  FIFO empty flag.
fifo_rd_water_level  in  DEPTH_WIDTH+1  FIFO read-side fill level.
m_data  out  DATA_WIDTH  sample to the processing core.
m_valid  out  1  m_data is valid.
m_ready  in  1  processing core accepts the sample.
m_sof  out  1  qualifies m_valid; marks the first sample of a frame.
m_eof  out  1  qualifies m_valid; marks the last sample of a frame.
busy  out  1  high in any state other than IDLE.
frame_cnt  out  CNT_WIDTH  count of completed frames.
underrun_err  out  1  sticky; set when the FIFO empties mid-frame.

Behaviour:
- Reset: while rst=1, on every clk edge:
  - state goes to IDLE, the 2-entry output buffer and in-flight flag clear, the read counter clears;
  - fifo_rd_en, m_valid, m_sof, m_eof, busy, underrun_err are 0, m_data is 0, frame_cnt is 0;
  - reset mid-frame abandons the frame with no eof and no frame_cnt increment. The FIFO itself is not reset by this block.
- State machine:
  - IDLE: if flush_req, go to FLUSH; else if enable, go to WAIT.
  - WAIT:
    - if flush_req, go to FLUSH (flush_req has priority);
    - else if !enable, go to IDLE;
    - else if fifo_rd_water_level >= FRAME_LEN, go to BURST and clear the read counter.
  - BURST: issues reads. After the FRAME_LEN-th fifo_rd_en, go to DRAIN.
  - DRAIN: stays until no read is in flight and the buffer is empty (the eof sample has been accepted). Then go to WAIT if enable, else IDLE.
  - FLUSH:
    - fifo_rd_en = !fifo_rd_empty; returned data is discarded and never reaches m_valid;
    - exit to IDLE after fifo_rd_empty has been seen high for 2 consecutive cycles with no read in flight.
- flush_req in BURST, DRAIN or FLUSH is ignored; it is not latched.
- enable is sampled only in IDLE, WAIT and DRAIN. Deasserting it mid-frame completes the current frame.
- Read issue in BURST:
  - fifo_rd_en = !fifo_rd_empty && (reads_issued < FRAME_LEN) && (occupancy + inflight - pop < 2);
  - occupancy = buffered entries (0 to 2); inflight = fifo_rd_en of the previous cycle; pop = m_valid && m_ready;
  - this sustains 1 sample/cycle when m_ready is held high, and never overflows the buffer.
- Data path:
  - fifo_rd_data is captured into the buffer on the cycle after fifo_rd_en;
  - the sop/eop tag is derived from the read index (index 0 = sof, index FRAME_LEN-1 = eof) and stored with the data;
  - output is in FIFO order; m_data, m_sof and m_eof are held stable while m_valid && !m_ready.
- Latency: first fifo_rd_en to first m_valid is 1 cycle when the buffer is empty. The first fifo_rd_en occurs 1 cycle after entry to BURST.
- frame_cnt increments by 1 on the m_valid && m_ready && m_eof handshake and wraps modulo 2^CNT_WIDTH.
- underrun_err:
  - set when state is BURST, reads_issued < FRAME_LEN and fifo_rd_empty=1;
  - meanwhile the block stalls (no read) and resumes when data arrives;
  - it is cleared only by rst.
- Reads are never issued when fifo_rd_empty=1, in any state.

Test Plan:
1. FRAME_LEN=256, FIFO preloaded with 300 samples, enable=1, m_ready=1 -> 256 consecutive fifo_rd_en; m_valid continuous for 256 cycles; m_sof on sample 0; m_eof on sample 255; frame_cnt=1; state returns to WAIT with 44 samples left, and no further reads.
2. Same preload, m_ready toggling 1,0,1,0 -> no sample lost or duplicated; data order matches the write order; fifo_rd_en never makes occupancy exceed 2; frame_cnt=1 after 256 accepts.
3. Water level 256 reached but empty asserts after 200 reads (forced by the bench) -> underrun_err=1 stays set; after 56 more samples are supplied, the frame completes with eof; frame_cnt=1.
4. enable dropped at read 100 of a frame -> the remaining 156 samples are delivered; then IDLE with busy=0; no new frame starts even with 512 buffered.
5. 37 samples buffered, state IDLE, flush_req pulse -> 37 reads; m_valid stays 0; FIFO empty; IDLE; frame_cnt unchanged. A flush_req pulse during BURST -> ignored.
6. rst asserted at read 120 with m_valid high -> on the next cycle all outputs are 0, frame_cnt=0, state IDLE; after rst release with enable=1 and 256 buffered, a fresh frame starts with m_sof.
